// File: rtl/fv_bank_req_arbiter.sv
// Round-robin issue scheduler in front of one FV bank controller. It converts node IDs to
// bank word addresses, allows one outstanding stream at a time, and blocks issue during bank loads.
module fv_bank_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NODE_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int FVN_W   = 7,
    parameter int TIMEOUT = 255,
    localparam int TAG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [FVN_W-1:0]          num_fv,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*NODE_W-1:0] req_node_id,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      load_sos,
    input  logic                      load_eos,
    output logic                      bank_req_valid,
    output logic [ADDR_W-1:0]         bank_req_addr,
    output logic [TAG_W-1:0]          bank_req_tag,
    input  logic                      pe_valid,
    input  logic                      pe_eos,
    input  logic [TAG_W-1:0]          pe_tag,
    output logic                      busy,
    output logic                      err_timeout,
    output logic                      err_conflict
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [TAG_W-1:0]    rr_ptr_r;
    logic [WD_W-1:0]     wd_r;
    logic                bank_req_valid_r;
    logic [ADDR_W-1:0]   bank_req_addr_r;
    logic [TAG_W-1:0]    bank_req_tag_r;
    logic                busy_r;
    logic                err_timeout_r;
    logic                err_conflict_r;

    logic [TAG_W:0]      sum_s;
    logic [TAG_W-1:0]    cand_s;
    logic [TAG_W-1:0]    win_idx_s;
    logic                win_found_s;
    logic                issue_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [NODE_W-1:0]   win_node_s;
    logic [FVN_W-1:0]    fv_inc_s;
    logic [FVN_W-1:0]    words_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [TAG_W-1:0]    rr_nxt_s;
    logic                eos_match_s;
    logic                wd_expire_s;

    // Round-robin search for the first valid requester at or after rr_ptr
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        sum_s       = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s = {1'b0, rr_ptr_r} + (TAG_W+1)'(k);
            if (sum_s >= (TAG_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (TAG_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[TAG_W-1:0];
            if (!win_found_s && req_valid[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign issue_s = (state_r == ST_IDLE) && !load_sos && win_found_s;

    // One-hot grant; suppressed while reset is asserted
    always_comb begin
        grant_s = '0;
        if (reset_n && issue_s) begin
            grant_s[win_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready = grant_s;

    // Select the winner's node ID
    always_comb begin
        win_node_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == TAG_W'(i)) begin
                win_node_s = req_node_id[i*NODE_W +: NODE_W];
            end else begin
                win_node_s = win_node_s;
            end
        end
    end

    // Words per FV round up at FVN_W bits; the product wraps modulo the bank size
    assign fv_inc_s = num_fv + FVN_W'(1);
    assign words_s  = fv_inc_s >> 1;
    assign addr_s   = ADDR_W'(win_node_s) * ADDR_W'(words_s);

    // Next round-robin pointer after the current winner
    always_comb begin
        rr_nxt_s = '0;
        if (win_idx_s == TAG_W'(NUM_REQ - 1)) begin
            rr_nxt_s = '0;
        end else begin
            rr_nxt_s = win_idx_s + TAG_W'(1);
        end
    end

    assign eos_match_s = pe_valid && pe_eos && (pe_tag == bank_req_tag_r);
    assign wd_expire_s = (wd_r == WD_W'(TIMEOUT));

    // Next-state logic; load_sos outranks requests in IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_sos) begin
                    state_nxt_s = ST_LOAD;
                end else if (win_found_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_eos) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_WAIT: begin
                if (eos_match_s || wd_expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, issue registers, watchdog and sticky error flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            rr_ptr_r         <= '0;
            wd_r             <= '0;
            bank_req_valid_r <= 1'b0;
            bank_req_addr_r  <= '0;
            bank_req_tag_r   <= '0;
            busy_r           <= 1'b0;
            err_timeout_r    <= 1'b0;
            err_conflict_r   <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            busy_r           <= (state_nxt_s != ST_IDLE);
            bank_req_valid_r <= issue_s;
            if (issue_s) begin
                bank_req_addr_r <= addr_s;
                bank_req_tag_r  <= win_idx_s;
                rr_ptr_r        <= rr_nxt_s;
                wd_r            <= '0;
            end else if ((state_r == ST_WAIT) && !wd_expire_s) begin
                wd_r <= wd_r + WD_W'(1);
            end else begin
                wd_r <= wd_r;
            end
            if ((state_r == ST_WAIT) && !eos_match_s && wd_expire_s) begin
                err_timeout_r <= 1'b1;
            end else begin
                err_timeout_r <= err_timeout_r;
            end
            if ((state_r == ST_WAIT) && load_sos) begin
                err_conflict_r <= 1'b1;
            end else begin
                err_conflict_r <= err_conflict_r;
            end
        end
    end

    assign bank_req_valid = bank_req_valid_r;
    assign bank_req_addr  = bank_req_addr_r;
    assign bank_req_tag   = bank_req_tag_r;
    assign busy           = busy_r;
    assign err_timeout    = err_timeout_r;
    assign err_conflict   = err_conflict_r;

endmodule
